// File: rtl/dds_sweep_ctrl.sv
// DDS phase sequencer: owns the phase accumulator and drives the sine table index,
// running either a fixed frequency or a clamped linear sweep with per-step dwell.
module dds_sweep_ctrl #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned PHASE_W = 8,
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               cfg_mode,
    input  logic               cfg_loop,
    input  logic [ACC_W-1:0]   cfg_fstart,
    input  logic [ACC_W-1:0]   cfg_fstop,
    input  logic [ACC_W-1:0]   cfg_fstep,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               start,
    input  logic               stop,
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_valid,
    output logic [ACC_W-1:0]   fcur,
    output logic               busy,
    output logic               sweep_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIXED = 2'd1,
        S_DWELL = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   fcur_q, fcur_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               phase_valid_q, busy_q, cfg_ready_q;
    logic               sweep_done_q, sweep_done_d;

    logic               mode_q, mode_d;
    logic               loop_q, loop_d;
    logic [ACC_W-1:0]   fstart_q, fstart_d;
    logic [ACC_W-1:0]   fstop_q, fstop_d;
    logic [ACC_W-1:0]   fstep_q, fstep_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               capture;
    logic               degenerate;
    logic [ACC_W:0]     step_sum;
    logic [DWELL_W-1:0] dwell_last;

    // Next-state, accumulator and sweep stepping
    always_comb begin
        capture      = cfg_valid && cfg_ready_q;
        mode_d       = capture ? cfg_mode   : mode_q;
        loop_d       = capture ? cfg_loop   : loop_q;
        fstart_d     = capture ? cfg_fstart : fstart_q;
        fstop_d      = capture ? cfg_fstop  : fstop_q;
        fstep_d      = capture ? cfg_fstep  : fstep_q;
        dwell_d      = capture ? cfg_dwell  : dwell_q;

        degenerate   = (fstep_d == '0) || (fstart_d >= fstop_d);
        step_sum     = {1'b0, fcur_q} + {1'b0, fstep_q};
        dwell_last   = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);

        state_d      = state_q;
        acc_d        = acc_q;
        fcur_d       = fcur_q;
        dwell_cnt_d  = dwell_cnt_q;
        sweep_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // start sees config captured in the same cycle; stop suppresses it
                if (start && !stop) begin
                    acc_d       = '0;
                    fcur_d      = fstart_d;
                    dwell_cnt_d = '0;
                    state_d     = (!mode_d || degenerate) ? S_FIXED : S_DWELL;
                end
            end
            default: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_q + fcur_q;
                    if (state_q == S_DWELL) begin
                        if (dwell_cnt_q == dwell_last) begin
                            dwell_cnt_d = '0;
                            if (fcur_q == fstop_q) begin
                                if (loop_q) begin
                                    fcur_d = fstart_q;
                                end else begin
                                    state_d      = S_HOLD;
                                    sweep_done_d = 1'b1;
                                end
                            end else if (step_sum >= {1'b0, fstop_q}) begin
                                fcur_d = fstop_q;
                            end else begin
                                fcur_d = step_sum[ACC_W-1:0];
                            end
                        end else begin
                            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                        end
                    end
                end
            end
        endcase

        phase_d = acc_d[ACC_W-1 -: PHASE_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            fcur_q        <= '0;
            phase_q       <= '0;
            dwell_cnt_q   <= '0;
            phase_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            cfg_ready_q   <= 1'b0;
            sweep_done_q  <= 1'b0;
            mode_q        <= 1'b0;
            loop_q        <= 1'b0;
            fstart_q      <= '0;
            fstop_q       <= '0;
            fstep_q       <= '0;
            dwell_q       <= '0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            fcur_q        <= fcur_d;
            phase_q       <= phase_d;
            dwell_cnt_q   <= dwell_cnt_d;
            phase_valid_q <= (state_d != S_IDLE);
            busy_q        <= (state_d != S_IDLE);
            cfg_ready_q   <= (state_d == S_IDLE);
            sweep_done_q  <= sweep_done_d;
            mode_q        <= mode_d;
            loop_q        <= loop_d;
            fstart_q      <= fstart_d;
            fstop_q       <= fstop_d;
            fstep_q       <= fstep_d;
            dwell_q       <= dwell_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign phase_out   = phase_q;
    assign phase_valid = phase_valid_q;
    assign fcur        = fcur_q;
    assign busy        = busy_q;
    assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a frequency-schedule model predicts every live
// phase sample; a monitor pops and compares whenever phase_valid is high.
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_mode;
    logic        cfg_loop;
    logic [31:0] cfg_fstart;
    logic [31:0] cfg_fstop;
    logic [31:0] cfg_fstep;
    logic [15:0] cfg_dwell;
    logic        start;
    logic        stop;
    logic [7:0]  phase_out;
    logic        phase_valid;
    logic [31:0] fcur;
    logic        busy;
    logic        sweep_done;

    dds_sweep_ctrl #(.ACC_W(32), .PHASE_W(8), .DWELL_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_loop   (cfg_loop),
        .cfg_fstart (cfg_fstart),
        .cfg_fstop  (cfg_fstop),
        .cfg_fstep  (cfg_fstep),
        .cfg_dwell  (cfg_dwell),
        .start      (start),
        .stop       (stop),
        .phase_out  (phase_out),
        .phase_valid(phase_valid),
        .fcur       (fcur),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    typedef struct {
        bit          mode;
        bit          loop;
        logic [31:0] fstart;
        logic [31:0] fstop;
        logic [31:0] fstep;
        logic [15:0] dwell;
    } cfg_t;

    typedef struct {
        logic [7:0]  phase;
        logic [31:0] fcur;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    cfg_t stored;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every live phase sample must match the next predicted sample
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && phase_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 64'(phase_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("phase_out", 64'(phase_out), 64'(e.phase));
                    chk("fcur", 64'(fcur), 64'(e.fcur));
                    chk("sweep_done", 64'(sweep_done), 64'(e.done));
                    chk("busy_run", 64'(busy), 64'(1));
                    chk("cfg_ready_run", 64'(cfg_ready), 64'(0));
                end
            end
        end
    end

    task automatic put_cfg(input cfg_t c);
        cfg_mode   = c.mode;
        cfg_loop   = c.loop;
        cfg_fstart = c.fstart;
        cfg_fstop  = c.fstop;
        cfg_fstep  = c.fstep;
        cfg_dwell  = c.dwell;
    endtask

    task automatic junk();
        cfg_t j;
        j.mode   = 1'($urandom_range(0, 1));
        j.loop   = 1'($urandom_range(0, 1));
        j.fstart = $urandom;
        j.fstop  = $urandom;
        j.fstep  = $urandom;
        j.dwell  = 16'($urandom);
        put_cfg(j);
        cfg_valid = 1'($urandom_range(0, 1));
        start     = ($urandom_range(0, 3) == 0);
    endtask

    // Drive one generation run of n live samples; called and returns on a negedge
    task automatic run(input cfg_t c, input bit drive_cfg, input bit same_cycle,
                       input int n, input bit do_stop);
        logic [31:0] freqs[$];
        logic [31:0] acc;
        logic [31:0] f;
        logic [31:0] last_f;
        logic [7:0]  last_p;
        longint      nx;
        int          d;
        int          idx;
        bit          fixed;
        bit          full;
        exp_t        e;

        if (drive_cfg) begin
            stored = c;
            put_cfg(c);
            cfg_valid = 1'b1;
            if (!same_cycle) begin
                @(negedge clk);
                cfg_valid = 1'b0;
            end
        end

        d     = (stored.dwell == 16'd0) ? 1 : int'(stored.dwell);
        fixed = !stored.mode || stored.fstep == 32'd0 || stored.fstart >= stored.fstop;
        full  = 1'b0;
        freqs.push_back(stored.fstart);
        if (!fixed) begin
            while (freqs.size() <= n) begin
                f = freqs[$];
                if (f == stored.fstop) begin
                    full = 1'b1;
                    break;
                end
                nx = longint'(f) + longint'(stored.fstep);
                freqs.push_back((nx >= longint'(stored.fstop)) ? stored.fstop : 32'(nx));
            end
        end

        acc    = 32'd0;
        last_f = 32'd0;
        last_p = 8'd0;
        for (int k = 0; k < n; k++) begin
            idx = k / d;
            if (fixed)                    f = stored.fstart;
            else if (idx < freqs.size())  f = freqs[idx];
            else if (stored.loop)         f = freqs[idx % freqs.size()];
            else                          f = stored.fstop;
            e.phase = acc[31:24];
            e.fcur  = f;
            e.done  = !fixed && !stored.loop && full && (k == d * freqs.size());
            exp_q.push_back(e);
            last_f = f;
            last_p = acc[31:24];
            acc    = acc + f;
        end

        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cfg_valid = 1'b0;
        for (int k = 0; k < n - 1; k++) begin
            junk();
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        if (do_stop) begin
            junk();
            stop  = 1'b1;
            start = 1'b1;
            @(negedge clk);
            stop      = 1'b0;
            start     = 1'b0;
            cfg_valid = 1'b0;
            chk("busy_after_stop", 64'(busy), 64'(0));
            chk("valid_after_stop", 64'(phase_valid), 64'(0));
            chk("cfg_ready_after_stop", 64'(cfg_ready), 64'(1));
            chk("done_after_stop", 64'(sweep_done), 64'(0));
            chk("fcur_held", 64'(fcur), 64'(last_f));
            chk("phase_held", 64'(phase_out), 64'(last_p));
            @(negedge clk);
        end
    endtask

    function automatic cfg_t mk(input bit mode, input bit loop, input logic [31:0] fstart,
                                input logic [31:0] fstop, input logic [31:0] fstep,
                                input logic [15:0] dwell);
        cfg_t c;
        c.mode   = mode;
        c.loop   = loop;
        c.fstart = fstart;
        c.fstop  = fstop;
        c.fstep  = fstep;
        c.dwell  = dwell;
        return c;
    endfunction

    initial begin
        cfg_t c;
        int   sh;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        put_cfg(mk(0, 0, 0, 0, 0, 0));
        stored = mk(0, 0, 0, 0, 0, 0);

        @(negedge clk);
        chk("rst_phase", 64'(phase_out), 64'(0));
        chk("rst_valid", 64'(phase_valid), 64'(0));
        chk("rst_fcur", 64'(fcur), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(sweep_done), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("cfg_ready_after_rst", 64'(cfg_ready), 64'(1));

        // Fixed frequency with config captured in the start cycle; phase wraps
        run(mk(0, 0, 32'h0100_0000, 32'h0, 32'h0, 16'd0), 1, 1, 300, 1);
        // Non-looping sweep, then a rerun on the stored config ending on the final step
        run(mk(1, 0, 32'h100, 32'h350, 32'h100, 16'd4), 1, 0, 40, 1);
        run(stored, 0, 0, 16, 1);
        // Looping sweep over three periods
        run(mk(1, 1, 32'h100, 32'h350, 32'h100, 16'd4), 1, 0, 54, 1);
        // Zero step degenerates to fixed
        run(mk(1, 0, 32'h0300_0000, 32'h0900_0000, 32'h0, 16'd2), 1, 1, 12, 1);
        // Step overflow must clamp to fstop
        run(mk(1, 0, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h200, 16'd2), 1, 0, 12, 1);
        // Zero dwell acts as one cycle per step
        run(mk(1, 0, 32'h100, 32'h400, 32'h100, 16'd0), 1, 0, 10, 1);

        // stop and start together in IDLE do nothing
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("idle_stop_start_busy", 64'(busy), 64'(0));
        chk("idle_stop_start_valid", 64'(phase_valid), 64'(0));

        for (int r = 0; r < 12; r++) begin
            sh = ($urandom_range(0, 1) == 1) ? 16 : 0;
            c = mk(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, 32'h2000)) << sh,
                   32'($urandom_range(0, 32'h4000)) << sh,
                   32'($urandom_range(0, 32'h800)) << sh,
                   16'($urandom_range(0, 5)));
            run(c, 1, 1'($urandom_range(0, 1)), $urandom_range(5, 60), 1);
        end

        // Asynchronous reset in the middle of a FIXED run
        run(mk(0, 0, 32'h0100_0000, 32'h0, 32'h0, 16'd0), 1, 0, 20, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_phase", 64'(phase_out), 64'(0));
        chk("midrst_valid", 64'(phase_valid), 64'(0));
        chk("midrst_fcur", 64'(fcur), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(sweep_done), 64'(0));
        stored = mk(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cfg_ready", 64'(cfg_ready), 64'(1));
        // Config was cleared, so a bare start runs at frequency zero
        run(stored, 0, 0, 8, 1);

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer for the sine lookup datapath. Owns the phase accumulator and drives the 8-bit phase index into the quarter-wave sine table. Runs either a fixed frequency or a linear frequency sweep (start/stop/step/dwell), configured over a valid/ready handshake from the SPI slave register block.

Parameters:
ACC_W, 32, phase accumulator and frequency-word width
PHASE_W, 8, phase index width; equals the lookup table phase input width
DWELL_W, 16, dwell counter width

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  configuration word set present
cfg_ready  output  1  controller can accept configuration (high only in IDLE)
cfg_mode  input  1  0 = fixed frequency, 1 = sweep
cfg_loop  input  1  sweep restarts from fstart after reaching fstop
cfg_fstart  input  ACC_W  start (or fixed) frequency word
cfg_fstop  input  ACC_W  sweep stop frequency word
cfg_fstep  input  ACC_W  sweep increment per dwell period
cfg_dwell  input  DWELL_W  cycles spent at each sweep frequency
start  input  1  begin generation (level sampled each clk)
stop  input  1  abort generation, return to IDLE
phase_out  output  PHASE_W  phase index to sine table, acc[ACC_W-1 -: PHASE_W], registered
phase_valid  output  1  phase_out is live
fcur  output  ACC_W  frequency word currently applied
busy  output  1  state is not IDLE
sweep_done  output  1  one-cycle pulse when a non-looping sweep reaches fstop

Behaviour:
- Reset (async, immediate): state = IDLE; acc, fcur, phase_out, config registers = 0; phase_valid, busy, sweep_done = 0; cfg_ready = 1 after reset deasserts.
- States: IDLE, FIXED, DWELL, HOLD.
- IDLE: cfg_ready = 1. A cycle with cfg_valid & cfg_ready captures all cfg_* fields. Outside IDLE, cfg_valid is ignored and nothing is captured.
- start in IDLE:
  - acc cleared to 0; fcur <= fstart.
  - Goes to FIXED if mode = 0, or if the sweep is degenerate (fstep = 0 or fstart >= fstop, unsigned). Otherwise goes to DWELL with dwell_cnt = 0.
- Same-cycle cfg_valid + start in IDLE: config is captured and start uses the newly captured values.
- Accumulator:
  - In every non-IDLE state, acc <= acc + fcur, modulo 2^ACC_W (wrap is intended).
  - phase_out <= acc_next top PHASE_W bits.
  - phase_valid = 1 from the cycle after start through the cycle stop is sampled; it falls the cycle after.
- Frequency change takes effect on the accumulator in the cycle after fcur updates.
- FIXED: fcur held constant until stop.
- DWELL:
  - Effective dwell = max(cfg_dwell, 1) cycles per frequency.
  - dwell_cnt increments each cycle. On reaching effective dwell − 1, dwell_cnt resets and a step is evaluated.
  - Step sum: nxt = fcur + fstep computed in ACC_W+1 bits.
  - If fcur == fstop: with loop = 1, fcur <= fstart and stay in DWELL; with loop = 0, go to HOLD and pulse sweep_done for exactly one cycle.
  - Else if nxt >= fstop (including carry-out): fcur <= fstop (clamp, no overshoot).
  - Else: fcur <= nxt[ACC_W-1:0].
- HOLD: generation continues at fstop until stop; sweep_done does not repeat.
- stop in any non-IDLE state: next state IDLE; acc and fcur hold their last values; busy falls next cycle.
  - stop and start in the same cycle: stop wins. In IDLE, that cycle does nothing.
  - stop coincident with the final step: IDLE is taken and sweep_done is not pulsed.
- start while non-IDLE: ignored, no restart.
- busy = (state != IDLE), registered with the state.
- Reset mid-sweep: immediate return to reset values; config is lost.

Test Plan:
- Reset: assert rst mid-cycle during FIXED -> all outputs 0 immediately; cfg_ready = 1 after release.
- Fixed mode: fstart = 0x01000000, start -> phase_out increments by 1 per clk (0x01, 0x02, ...), wraps 0xFF->0x00 after 256 cycles, busy = 1.
- Sweep no-loop: fstart = 0x100, fstep = 0x100, fstop = 0x350, dwell = 4 -> fcur sequence 0x100, 0x200, 0x300, 0x350, each held 4 cycles; then sweep_done pulses once, state HOLD, fcur stays 0x350.
- Sweep loop: same config with loop = 1 -> after 0x350 dwell, fcur returns to 0x100; sweep_done never asserts over 3 periods.
- Degenerate/overflow: fstep = 0 -> fixed at fstart. Separately fstart = 0xFFFFFF00, fstep = 0x200, fstop = 0xFFFFFFF0 -> clamps to 0xFFFFFFF0, no wrap to a small value. dwell = 0 behaves as dwell = 1.
- Handshake/precedence: cfg_valid during DWELL -> not captured, cfg_ready = 0. stop + start same cycle in FIXED -> IDLE next cycle. cfg_valid + start in IDLE -> runs with new fstart.
